mips_host_ctrl: RTL

Parametrised host-access controller placed between an external host, the mips core and its instruction/data memories; successor to the fixed host/core muxing in the memory top level.
Owns all memory-port arbitration through one state machine: program load, data preload, run launch, run monitoring with cycle count and timeout, and registered data-memory readback.
The host talks through a single valid/ready command channel plus a response strobe; the core sees memory only while in RUN.

---
 rtl/mips_host_ctrl_pkg.sv | 25 ++
 rtl/mips_host_ctrl_if.sv | 29 ++
 rtl/mips_host_ctrl_run_timer.sv | 38 +++
 rtl/mips_host_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_host_ctrl_pkg.sv
// mips_host_ctrl_pkg
// Shared definitions for the mips host-access controller: host command
// encodings, controller state encoding and reset-value constants.
package mips_host_ctrl_pkg;

  // Host command channel encodings (host_cmd)
  typedef enum logic [1:0] {
    CMD_WI    = 2'b00,  // write instruction memory
    CMD_WD    = 2'b01,  // write data memory
    CMD_START = 2'b10,  // launch a core run
    CMD_RD    = 2'b11   // read data memory
  } host_cmd_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_RUN     = 2'b10
  } ctrl_state_e;

  // Reset values
  localparam ctrl_state_e RST_STATE = ST_IDLE;
  localparam logic        RST_FLAG  = 1'b0;

endpackage

// File: rtl/mips_host_ctrl_if.sv
// mips_host_ctrl_if
// Host command / response channel of the mips host-access controller.
//   host_valid/host_ready : command handshake (accepted when both high)
//   host_cmd              : command code (see host_cmd_e)
//   host_adr/host_wdata   : word address and write data of the command
//   rsp_valid/rsp_data    : one-cycle read response strobe and data
// master = external host, slave = controller.
interface mips_host_ctrl_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADRBITS = 10
);
  logic                          host_valid;
  logic                          host_ready;
  mips_host_ctrl_pkg::host_cmd_e host_cmd;
  logic [ADRBITS-1:0]            host_adr;
  logic [WIDTH-1:0]              host_wdata;
  logic                          rsp_valid;
  logic [WIDTH-1:0]              rsp_data;

  modport master (
    output host_valid, host_cmd, host_adr, host_wdata,
    input  host_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  host_valid, host_cmd, host_adr, host_wdata,
    output host_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mips_host_ctrl_run_timer.sv
// mips_host_ctrl_run_timer
// Saturating run-cycle counter.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear (priority over en)
//   en         : count one cycle
//   count      : current count, sticks at 2**TOBITS-1
//   sat        : high on an enabled cycle whose increment reaches (or is
//                already at) saturation, i.e. the last countable cycle
module mips_host_ctrl_run_timer #(
  parameter int unsigned TOBITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [TOBITS-1:0] count,
  output logic              sat
);

  localparam logic [TOBITS-1:0] CNT_MAX  = '1;
  localparam logic [TOBITS-1:0] CNT_LAST = {{(TOBITS-1){1'b1}}, 1'b0};
  localparam logic [TOBITS-1:0] CNT_ONE  = {{(TOBITS-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

  // Asserted one cycle early so the controller leaves RUN on the same edge
  // that the counter reaches its maximum.
  assign sat = en && (count >= CNT_LAST);

endmodule

// File: rtl/mips_host_ctrl.sv
// mips_host_ctrl
// Host-access controller between an external host, the mips core and its
// instruction/data memories. One FSM (IDLE / RD_WAIT / RUN) owns all memory
// port arbitration: program load, data preload, run launch, run monitoring
// with cycle count and timeout, and registered data-memory readback.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   host                : host command/response channel (slave modport)
//   core_start          : one-cycle start pulse to the core (registered)
//   core_done           : core done level
//   core_we/adr/wdata   : core data-memory write request (used only in RUN)
//   imem_we/adr/wdata   : instruction memory write port
//   dmem_we/adr/wdata   : data memory port
//   dmem_rdata          : data memory read data, 1-cycle synchronous latency
//   run_cycles          : cycles spent in last/current run
//   busy                : high in RUN
//   timeout             : sticky, last run hit counter saturation
//   ran_ok              : sticky, last run ended by core_done
module mips_host_ctrl
  import mips_host_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADRBITS = 10,
  parameter int unsigned TOBITS  = 16
) (
  input  logic               clk,
  input  logic               reset,
  mips_host_ctrl_if.slave    host,
  output logic               core_start,
  input  logic               core_done,
  input  logic               core_we,
  input  logic [ADRBITS-1:0] core_adr,
  input  logic [WIDTH-1:0]   core_wdata,
  output logic               imem_we,
  output logic [ADRBITS-1:0] imem_adr,
  output logic [WIDTH-1:0]   imem_wdata,
  output logic               dmem_we,
  output logic [ADRBITS-1:0] dmem_adr,
  output logic [WIDTH-1:0]   dmem_wdata,
  input  logic [WIDTH-1:0]   dmem_rdata,
  output logic [TOBITS-1:0]  run_cycles,
  output logic               busy,
  output logic               timeout,
  output logic               ran_ok
);

  ctrl_state_e        state, state_n;
  logic               host_ready_c;
  logic               accept;
  logic               rsp_valid_c;
  logic [WIDTH-1:0]   rsp_data_c;
  logic               start_acc;
  logic               tmr_en;
  logic               tmr_sat;
  logic               set_ok;
  logic               set_to;
  logic [ADRBITS-1:0] dmem_adr_q;

  // Commands are refused while reset is held so every output stays low.
  assign host_ready_c = (state == ST_IDLE) && !reset;
  assign accept       = host.host_valid && host_ready_c;

  assign host.host_ready = host_ready_c;
  assign host.rsp_valid  = rsp_valid_c;
  assign host.rsp_data   = rsp_data_c;
  assign busy            = (state == ST_RUN);

  mips_host_ctrl_run_timer #(
    .TOBITS (TOBITS)
  ) u_run_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .en    (tmr_en),
    .count (run_cycles),
    .sat   (tmr_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RST_STATE;
      core_start <= RST_FLAG;
      timeout    <= RST_FLAG;
      ran_ok     <= RST_FLAG;
      dmem_adr_q <= '0;
    end else begin
      state      <= state_n;
      core_start <= start_acc;
      dmem_adr_q <= dmem_adr;
      if (start_acc) begin
        timeout <= 1'b0;
        ran_ok  <= 1'b0;
      end else if (set_ok) begin
        ran_ok  <= 1'b1;
        timeout <= 1'b0;
      end else if (set_to) begin
        timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    imem_we     = 1'b0;
    imem_adr    = '0;
    imem_wdata  = '0;
    dmem_we     = 1'b0;
    dmem_adr    = dmem_adr_q;
    dmem_wdata  = '0;
    rsp_valid_c = 1'b0;
    rsp_data_c  = '0;
    start_acc   = 1'b0;
    tmr_en      = 1'b0;
    set_ok      = 1'b0;
    set_to      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (host.host_cmd)
            CMD_WI: begin
              imem_we    = 1'b1;
              imem_adr   = host.host_adr;
              imem_wdata = host.host_wdata;
            end
            CMD_WD: begin
              dmem_we    = 1'b1;
              dmem_adr   = host.host_adr;
              dmem_wdata = host.host_wdata;
            end
            CMD_RD: begin
              dmem_adr = host.host_adr;
              state_n  = ST_RD_WAIT;
            end
            CMD_START: begin
              start_acc = 1'b1;
              state_n   = ST_RUN;
            end
            default: ;
          endcase
        end
      end

      ST_RD_WAIT: begin
        // dmem_adr_q still holds the read address, so memory keeps it.
        rsp_valid_c = 1'b1;
        rsp_data_c  = dmem_rdata;
        state_n     = ST_IDLE;
      end

      ST_RUN: begin
        tmr_en     = 1'b1;
        dmem_we    = core_we;
        dmem_adr   = core_adr;
        dmem_wdata = core_wdata;
        // Done is not trusted during the start pulse; done beats timeout.
        if (core_done && !core_start) begin
          set_ok  = 1'b1;
          state_n = ST_IDLE;
        end else if (tmr_sat) begin
          set_to  = 1'b1;
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule
